// File: rtl/database_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : database_reader_pkg
// Purpose : Shared debug definitions for the snapshot database dumpers.
//           Holds the database control-select codes and the reader FSM
//           state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package database_reader_pkg;

    // Database control-select codes. Codes 12..15 make the database clear
    // itself, so a reader must never drive them.
    localparam logic [3:0] CTRL_HOLD       = 4'd0;
    localparam logic [3:0] CTRL_CAPTURE    = 4'd1;
    localparam logic [3:0] CTRL_FIRST_READ = 4'd2;
    localparam logic [3:0] CTRL_LAST_READ  = 4'd11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SELECT  = 3'd2,
        LOAD    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/database_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : database_reader_if
// Purpose : Bundles the reader's command, database and UART TX signals.
// Ports   : i_start    - one-cycle dump request
//           i_dato     - database read word
//           o_control  - database control select
//           o_tx_data  - byte to UART TX
//           o_tx_start - UART TX start pulse
//           i_tx_done  - UART TX byte-sent pulse
//           o_busy     - dump in progress
//           o_done     - dump-complete pulse
//           slave modport = reader side, master modport = environment side
// Rev     : 1.0  initial release
// ============================================================================
interface database_reader_if #(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int CANT_BITS_CONTROL    = 4,
    parameter int BYTE_WIDTH           = 8
);
    logic                            i_start;
    logic [LONGITUD_INSTRUCCION-1:0] i_dato;
    logic [CANT_BITS_CONTROL-1:0]    o_control;
    logic [BYTE_WIDTH-1:0]           o_tx_data;
    logic                            o_tx_start;
    logic                            i_tx_done;
    logic                            o_busy;
    logic                            o_done;

    modport slave (
        input  i_start, i_dato, i_tx_done,
        output o_control, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport master (
        output i_start, i_dato, i_tx_done,
        input  o_control, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/database_word_serializer.sv
`default_nettype none
// ============================================================================
// Module  : database_word_serializer
// Purpose : Word-to-byte serializer for debug dumpers. Loads a word, presents
//           its most significant byte, and shifts one byte left per shift
//           request. Flags when the byte on display is the last of the word.
// Ports   : clk_i   - clock
//           rst_i   - synchronous active-high reset
//           load_i  - load word_i, byte count to 0
//           word_i  - word to serialize
//           shift_i - advance to next byte
//           byte_o  - current byte (registered MSB slice)
//           last_o  - current byte is the final byte of the word
// Rev     : 1.0  initial release
// ============================================================================
module database_word_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  load_i,
    input  wire logic [WORD_WIDTH-1:0] word_i,
    input  wire logic                  shift_i,
    output logic      [BYTE_WIDTH-1:0] byte_o,
    output logic                       last_o
);
    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (load_i) begin
            shift_d = word_i;
            count_d = '0;
        end else if (shift_i) begin
            // Zeros fill from the right, so the register is empty once the
            // whole word has been sent.
            shift_d = shift_q << BYTE_WIDTH;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign byte_o = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
    assign last_o = (count_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/database_reader.sv
`default_nettype none
// ============================================================================
// Module  : database_reader
// Purpose : Reading end of the pipeline debug snapshot database. On i_start
//           it captures the snapshot (code 1), steps the select through
//           FIRST_SELECT..LAST_SELECT, and streams every returned word MSB
//           byte first to the debug UART transmitter.
// Ports   : i_clock - clock, rising edge
//           i_reset - synchronous active-high reset
//           bus     - database_reader_if.slave (start, database pair,
//                     UART TX handshake, busy/done status)
// Rev     : 1.0  initial release
// ============================================================================
module database_reader
    import database_reader_pkg::*;
#(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int CANT_BITS_CONTROL    = 4,
    parameter int FIRST_SELECT         = 2,
    parameter int LAST_SELECT          = 11,
    parameter int BYTE_WIDTH           = 8
) (
    input  wire logic        i_clock,
    input  wire logic        i_reset,
    database_reader_if.slave bus
);
    localparam logic [CANT_BITS_CONTROL-1:0] SEL_FIRST = CANT_BITS_CONTROL'(FIRST_SELECT);
    localparam logic [CANT_BITS_CONTROL-1:0] SEL_LAST  = CANT_BITS_CONTROL'(LAST_SELECT);

    state_t                       state_q, state_d;
    logic [CANT_BITS_CONTROL-1:0] select_q, select_d;
    logic [CANT_BITS_CONTROL-1:0] control_q, control_d;
    logic                         tx_start_q, tx_start_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic                         ser_load;
    logic                         ser_shift;
    logic                         ser_last;
    logic [BYTE_WIDTH-1:0]        ser_byte;

    database_word_serializer #(
        .WORD_WIDTH (LONGITUD_INSTRUCCION),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_serializer (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .load_i  (ser_load),
        .word_i  (bus.i_dato),
        .shift_i (ser_shift),
        .byte_o  (ser_byte),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = CAPTURE;
            CAPTURE: begin
                select_d = SEL_FIRST;
                state_d  = SELECT;
            end
            SELECT:  state_d = LOAD;
            LOAD: begin
                // The database registered the select one edge ago, so
                // i_dato holds the requested word now.
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    ser_shift = 1'b1;
                    if (!ser_last) begin
                        state_d = SEND;
                    end else if (select_q < SEL_LAST) begin
                        select_d = select_q + 1'b1;
                        state_d  = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so each
        // one lines up with the state it belongs to.
        control_d = CANT_BITS_CONTROL'(CTRL_HOLD);
        case (state_d)
            CAPTURE: control_d = CANT_BITS_CONTROL'(CTRL_CAPTURE);
            SELECT:  control_d = select_d;
            default: control_d = CANT_BITS_CONTROL'(CTRL_HOLD);
        endcase
        tx_start_d = (state_d == SEND);
        busy_d     = (state_d != IDLE) && (state_d != DONE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            select_q   <= SEL_FIRST;
            control_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            control_q  <= control_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_control  = control_q;
    assign bus.o_tx_data  = ser_byte;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_database_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_database_reader
// Purpose : Self-checking bench for database_reader. A database model
//           answers selects one edge late, a UART model acknowledges bytes
//           after a programmable delay, and a monitor checks every cycle
//           against the expected byte stream built from the database image.
// Rev     : 1.0  initial release
// ============================================================================
module tb_database_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    database_reader_if #(
        .LONGITUD_INSTRUCCION (32),
        .CANT_BITS_CONTROL    (4),
        .BYTE_WIDTH           (8)
    ) bus ();

    database_reader #(
        .LONGITUD_INSTRUCCION (32),
        .CANT_BITS_CONTROL    (4),
        .FIRST_SELECT         (2),
        .LAST_SELECT          (11),
        .BYTE_WIDTH           (8)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- database model ----------------
    logic [31:0] db_mem [0:15];
    logic [31:0] dato_q = 32'h0;
    always @(posedge clk) begin
        if (bus.o_control >= 4'd2 && bus.o_control <= 4'd11)
            dato_q <= db_mem[bus.o_control];
    end
    assign bus.i_dato = dato_q;

    // ---------------- start drivers ----------------
    logic start_main = 1'b0;
    logic start_spur = 1'b0;
    assign bus.i_start = start_main | start_spur;

    // ---------------- UART TX model ----------------
    int   uart_delay = 5;
    bit   uart_rand  = 1'b0;
    bit   spur_done  = 1'b0;
    bit   spur_start = 1'b0;
    int   rst_gen    = 0;
    int   ack_cnt    = 0;
    logic done_drv   = 1'b0;
    assign bus.i_tx_done = done_drv;

    initial begin
        int d;
        int g;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start && !rst) begin
                g = rst_gen;
                d = uart_rand ? int'($urandom_range(1, 12)) : uart_delay;
                if (spur_done) done_drv = 1'b1;   // lands in the SEND cycle
                @(posedge clk);
                #1 done_drv = 1'b0;
                repeat (d - 1) @(posedge clk);
                #1;
                if (rst_gen == g && !rst) begin
                    done_drv = 1'b1;
                    ack_cnt++;
                    @(posedge clk);
                    #1 done_drv = 1'b0;
                end
            end
        end
    end

    // ---------------- spurious start generator ----------------
    initial begin
        forever begin
            repeat (7) @(negedge clk);
            if (spur_start && bus.o_busy) begin
                @(posedge clk);
                #1 start_spur = 1'b1;
                @(posedge clk);
                #1 start_spur = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int         tx_cyc_q[$];
    logic [3:0] ctrl_q[$];
    int         done_cnt    = 0;
    bit         outstanding = 1'b0;
    bit         prev_start  = 1'b0;
    logic [3:0] prev_ctrl   = 4'd0;
    logic [7:0] held        = 8'h0;
    int         ack_seen    = 0;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            prev_start  = 1'b0;
            prev_ctrl   = 4'd0;
            ack_seen    = ack_cnt;
        end else begin
            if (ack_cnt != ack_seen) begin
                outstanding = 1'b0;
                ack_seen    = ack_cnt;
            end
            chk("ctrl_range", 32'(bus.o_control <= 4'd11), 1);
            if (bus.o_tx_start) begin
                chk("tx_start_back_to_back", 32'(prev_start), 0);
                chk("tx_start_before_done", 32'(outstanding), 0);
                chk("busy_during_tx", 32'(bus.o_busy), 1);
                got_q.push_back(bus.o_tx_data);
                tx_cyc_q.push_back(cyc);
                outstanding = 1'b1;
                held        = bus.o_tx_data;
            end else if (outstanding) begin
                chk("tx_data_hold", 32'(bus.o_tx_data), 32'(held));
                chk("ctrl_zero_in_wait", 32'(bus.o_control), 0);
            end
            if (bus.o_control != 4'd0) begin
                chk("ctrl_one_cycle", 32'(bus.o_control != prev_ctrl), 1);
                ctrl_q.push_back(bus.o_control);
            end
            if (bus.o_done) begin
                done_cnt++;
                chk("busy_low_at_done", 32'(bus.o_busy), 0);
            end
            prev_start = bus.o_tx_start;
            prev_ctrl  = bus.o_control;
        end
    end

    // ---------------- expected stream model ----------------
    logic [7:0] exp_q[$];

    task automatic build_exp();
        logic [31:0] w;
        exp_q.delete();
        for (int c = 2; c <= 11; c++) begin
            w = db_mem[c];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((w >> (24 - 8 * b)) & 32'hFF));
        end
    endtask

    task automatic randomize_db();
        for (int c = 0; c < 16; c++) db_mem[c] = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_control"},  32'(bus.o_control), 0);
        chk({tag, "_tx_data"},  32'(bus.o_tx_data), 0);
        chk({tag, "_tx_start"}, 32'(bus.o_tx_start), 0);
        chk({tag, "_busy"},     32'(bus.o_busy), 0);
        chk({tag, "_done"},     32'(bus.o_done), 0);
    endtask

    int last_gb;

    task automatic run_dump(input string tag);
        int gb, cb, db, sc, t;
        build_exp();
        gb = got_q.size();
        cb = ctrl_q.size();
        db = done_cnt;
        last_gb = gb;
        @(posedge clk);
        #1 start_main = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1 start_main = 1'b0;
        t = 0;
        while (done_cnt == db && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != db), 1);
        repeat (30) @(negedge clk);
        chk({tag, "_byte_count"}, 32'(got_q.size() - gb), 40);
        for (int i = 0; i < 40; i++)
            if (gb + i < got_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[gb + i]), 32'(exp_q[i]));
        chk({tag, "_done_count"}, 32'(done_cnt - db), 1);
        chk({tag, "_ctrl_count"}, 32'(ctrl_q.size() - cb), 11);
        for (int k = 0; k < 11; k++)
            if (cb + k < ctrl_q.size())
                chk($sformatf("%s_ctrl%0d", tag, k), 32'(ctrl_q[cb + k]), 32'(k + 1));
        if (gb < tx_cyc_q.size())
            chk({tag, "_latency"}, 32'(tx_cyc_q[gb] - sc), 4);
        chk({tag, "_idle_busy"}, 32'(bus.o_busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ab, t;
        rst = 1'b1;
        for (int c = 0; c < 16; c++) db_mem[c] = 32'h0A0B0C00 + c;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Reset held three cycles while idle.
        #1 rst = 1'b1;
        rst_gen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs_zero("reset");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Full dump with the fixed image, plus hand-computed pins.
        run_dump("full");
        chk("model_pin_code4_lsb", 32'(exp_q[11]), 32'h04);
        if (got_q.size() >= 40) begin
            chk("pin_byte0",  32'(got_q[0]),  32'h0A);
            chk("pin_byte3",  32'(got_q[3]),  32'h02);
            chk("pin_byte8",  32'(got_q[8]),  32'h0A);
            chk("pin_byte9",  32'(got_q[9]),  32'h0B);
            chk("pin_byte10", 32'(got_q[10]), 32'h0C);
            chk("pin_byte11", 32'(got_q[11]), 32'h04);
            chk("pin_byte39", 32'(got_q[39]), 32'h0B);
        end

        // Slow transmitter.
        uart_delay = 200;
        run_dump("slow");
        uart_delay = 5;

        // Spurious start and done inputs.
        spur_start = 1'b1;
        spur_done  = 1'b1;
        run_dump("spurious");
        spur_start = 1'b0;
        spur_done  = 1'b0;

        // Reset mid-dump after the 17th acknowledge.
        randomize_db();
        ab = ack_cnt;
        @(posedge clk);
        #1 start_main = 1'b1;
        @(posedge clk);
        #1 start_main = 1'b0;
        t = 0;
        while ((ack_cnt - ab) < 17 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("midreset_17_acks", 32'(ack_cnt - ab), 17);
        @(posedge clk);
        #1 rst = 1'b1;
        rst_gen++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (20) @(negedge clk);
        check_outputs_zero("midreset_idle");
        run_dump("restart");

        // Randomized images, transmitter delays and spurious inputs.
        uart_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            randomize_db();
            spur_done  = 1'($urandom_range(0, 1));
            spur_start = 1'($urandom_range(0, 1));
            run_dump($sformatf("rand%0d", r));
            spur_start = 1'b0;
        end
        uart_rand = 1'b0;
        spur_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
